multicycle_control_unit: RTL and testbench

Parametrised multi-cycle successor to the single-cycle RV32I control decoder. It sequences every instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states and drives the shared-datapath control strobes. It handshakes with a single unified memory port and flags illegal opcodes and memory timeouts through a sticky trap. It also counts retired instructions. It sits between the instruction register (opcode field) and the multi-cycle datapath muxes, register file and memory port.

---
 rtl/multicycle_control_unit.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK FSM
// with memory wait timeout, sticky trap and retired-instruction counter.
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          ENABLE_JAL  = 1'b1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       Opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [1:0]       MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             PCSrc,
  output logic             Branch,
  output logic             trap,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int unsigned WAIT_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_MEM   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t            cur_state;
  state_t            nxt_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              retire_c;
  logic              timeout_c;
  logic              is_mem_c;

  assign state = cur_state;

  // Next-state and control-strobe decode; outputs depend on state (and mem_ready in FETCH)
  always_comb begin
    nxt_state = cur_state;
    retire_c  = 1'b0;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemtoReg  = 2'b00;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    PCSrc     = 1'b0;
    Branch    = 1'b0;
    trap      = 1'b0;
    timeout_c = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(WAIT_LAST));
    is_mem_c  = (cur_state == S_FETCH) || (cur_state == S_MEM_RD) || (cur_state == S_MEM_WR);

    case (cur_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_ready) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          nxt_state = S_DECODE;
        end else if (timeout_c) begin
          nxt_state = S_TRAP;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b10;
        case (Opcode)
          OP_R:               nxt_state = S_EXEC_R;
          OP_I:               nxt_state = S_EXEC_I;
          OP_LOAD, OP_STORE:  nxt_state = S_MEM_ADDR;
          OP_BRANCH:          nxt_state = S_BRANCH;
          OP_JAL:             nxt_state = ENABLE_JAL ? S_JAL : S_TRAP;
          default:            nxt_state = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 2'b10;
        nxt_state = S_WB_ALU;
      end
      S_EXEC_I: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ALUOp     = 2'b11;
        nxt_state = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        // IR is re-checked; anything that is no longer a load/store is treated as illegal
        if (Opcode == OP_LOAD)       nxt_state = S_MEM_RD;
        else if (Opcode == OP_STORE) nxt_state = S_MEM_WR;
        else                         nxt_state = S_TRAP;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready)      nxt_state = S_WB_MEM;
        else if (timeout_c) nxt_state = S_TRAP;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          nxt_state = S_FETCH;
          retire_c  = 1'b1;
        end else if (timeout_c) begin
          nxt_state = S_TRAP;
        end
      end
      S_WB_MEM: begin
        RegWrite  = 1'b1;
        MemtoReg  = 2'b01;
        nxt_state = S_FETCH;
        retire_c  = 1'b1;
      end
      S_WB_ALU: begin
        RegWrite  = 1'b1;
        nxt_state = S_FETCH;
        retire_c  = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 2'b01;
        Branch    = 1'b1;
        PCSrc     = 1'b1;
        nxt_state = S_FETCH;
        retire_c  = 1'b1;
      end
      S_JAL: begin
        RegWrite  = 1'b1;
        MemtoReg  = 2'b10;
        PCWrite   = 1'b1;
        PCSrc     = 1'b1;
        nxt_state = S_FETCH;
        retire_c  = 1'b1;
      end
      S_TRAP: begin
        trap      = 1'b1;
        nxt_state = S_TRAP;
      end
      default: nxt_state = S_TRAP;
    endcase
  end

  // State, wait counter (cleared on every state change) and retire counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_state <= S_FETCH;
      wait_cnt  <= '0;
      retired   <= '0;
    end else begin
      cur_state <= nxt_state;
      if (nxt_state != cur_state)
        wait_cnt <= '0;
      else if (is_mem_c && !mem_ready)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (retire_c)
        retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: two configurations share one stimulus stream and
// are checked every cycle against an instruction-plan model, plus directed literal sequences.
module tb_multicycle_control_unit;

  localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC_R = 2, S_EXEC_I = 3, S_MEM_ADDR = 4,
                 S_MEM_RD = 5, S_MEM_WR = 6, S_WB_MEM = 7, S_WB_ALU = 8, S_BRANCH = 9,
                 S_JAL = 10, S_TRAP = 11;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011,
                         OP_S = 7'b0100011, OP_B = 7'b1100011, OP_J = 7'b1101111;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       mem_ready;
  logic [6:0] Opcode;

  logic a_PCWrite, a_IRWrite, a_IorD, a_MemRead, a_MemWrite, a_RegWrite, a_ALUSrcA;
  logic a_PCSrc, a_Branch, a_trap;
  logic [1:0] a_MemtoReg, a_ALUSrcB, a_ALUOp;
  logic [3:0] a_state;
  logic [31:0] a_retired;

  logic b_PCWrite, b_IRWrite, b_IorD, b_MemRead, b_MemWrite, b_RegWrite, b_ALUSrcA;
  logic b_PCSrc, b_Branch, b_trap;
  logic [1:0] b_MemtoReg, b_ALUSrcB, b_ALUOp;
  logic [3:0] b_state;
  logic [1:0] b_retired;

  always #5 clk = ~clk;

  multicycle_control_unit #(.MEM_TIMEOUT(16), .ENABLE_JAL(1'b1), .CNT_W(32)) dut_a (
    .clk(clk), .reset_n(reset_n), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(a_PCWrite), .IRWrite(a_IRWrite), .IorD(a_IorD), .MemRead(a_MemRead),
    .MemWrite(a_MemWrite), .MemtoReg(a_MemtoReg), .RegWrite(a_RegWrite),
    .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB), .ALUOp(a_ALUOp), .PCSrc(a_PCSrc),
    .Branch(a_Branch), .trap(a_trap), .state(a_state), .retired(a_retired));

  multicycle_control_unit #(.MEM_TIMEOUT(4), .ENABLE_JAL(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(b_PCWrite), .IRWrite(b_IRWrite), .IorD(b_IorD), .MemRead(b_MemRead),
    .MemWrite(b_MemWrite), .MemtoReg(b_MemtoReg), .RegWrite(b_RegWrite),
    .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB), .ALUOp(b_ALUOp), .PCSrc(b_PCSrc),
    .Branch(b_Branch), .trap(b_trap), .state(b_state), .retired(b_retired));

  logic [15:0] ctl_a, ctl_b;
  assign ctl_a = {a_PCWrite, a_IRWrite, a_IorD, a_MemRead, a_MemWrite, a_MemtoReg, a_RegWrite,
                  a_ALUSrcA, a_ALUSrcB, a_ALUOp, a_PCSrc, a_Branch, a_trap};
  assign ctl_b = {b_PCWrite, b_IRWrite, b_IorD, b_MemRead, b_MemWrite, b_MemtoReg, b_RegWrite,
                  b_ALUSrcA, b_ALUSrcB, b_ALUOp, b_PCSrc, b_Branch, b_trap};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: per configuration, the current state plus the remaining planned states of the instruction
  int     m_to[2] = '{16, 4};
  bit     m_ej[2] = '{1'b1, 1'b0};
  int     m_cw[2] = '{32, 2};
  int     m_st[2];
  int     m_wc[2];
  longint m_ret[2];
  int     m_plan[2][3];
  int     m_plen[2];
  int     m_pidx[2];
  bit     model_valid = 1'b0;

  function automatic void plan_for(input int m, input logic [6:0] op);
    m_pidx[m] = 0;
    case (op)
      OP_R: begin m_plan[m][0] = S_EXEC_R; m_plan[m][1] = S_WB_ALU; m_plen[m] = 2; end
      OP_I: begin m_plan[m][0] = S_EXEC_I; m_plan[m][1] = S_WB_ALU; m_plen[m] = 2; end
      OP_L: begin m_plan[m][0] = S_MEM_ADDR; m_plan[m][1] = S_MEM_RD; m_plan[m][2] = S_WB_MEM; m_plen[m] = 3; end
      OP_S: begin m_plan[m][0] = S_MEM_ADDR; m_plan[m][1] = S_MEM_WR; m_plen[m] = 2; end
      OP_B: begin m_plan[m][0] = S_BRANCH; m_plen[m] = 1; end
      OP_J: begin m_plan[m][0] = m_ej[m] ? S_JAL : S_TRAP; m_plen[m] = 1; end
      default: begin m_plan[m][0] = S_TRAP; m_plen[m] = 1; end
    endcase
  endfunction

  function automatic void take_next(input int m, output int nxt, output bit rt);
    if (m_pidx[m] < m_plen[m]) begin
      nxt = m_plan[m][m_pidx[m]];
      m_pidx[m]++;
      rt = 1'b0;
    end else begin
      nxt = S_FETCH;
      rt  = 1'b1;
    end
  endfunction

  function automatic bit timed_out(input int m);
    return (m_to[m] != 0) && (m_wc[m] == m_to[m] - 1);
  endfunction

  function automatic void model_step(input int m);
    int nxt;
    bit rt;
    nxt = m_st[m];
    rt  = 1'b0;
    if (!reset_n) begin
      m_st[m] = S_FETCH; m_wc[m] = 0; m_ret[m] = 0; m_plen[m] = 0; m_pidx[m] = 0;
      return;
    end
    case (m_st[m])
      S_TRAP:  nxt = S_TRAP;
      S_FETCH: if (mem_ready) nxt = S_DECODE; else if (timed_out(m)) nxt = S_TRAP;
      S_MEM_RD, S_MEM_WR: if (mem_ready) take_next(m, nxt, rt); else if (timed_out(m)) nxt = S_TRAP;
      S_DECODE: begin plan_for(m, Opcode); take_next(m, nxt, rt); end
      S_MEM_ADDR: begin
        plan_for(m, Opcode);
        if (m_plen[m] > 1 && m_plan[m][0] == S_MEM_ADDR) m_pidx[m] = 1;
        else begin m_plan[m][0] = S_TRAP; m_plen[m] = 1; end
        take_next(m, nxt, rt);
      end
      default: take_next(m, nxt, rt);
    endcase
    if (nxt != m_st[m]) m_wc[m] = 0;
    else if (!mem_ready) m_wc[m]++;
    m_st[m] = nxt;
    if (rt) m_ret[m] = (m_ret[m] + 1) % (longint'(1) << m_cw[m]);
  endfunction

  function automatic logic [15:0] exp_ctl(input int st, input logic rdy);
    logic pcw, irw, iord, mrd, mwr, rw, asa, pcs, br, trp;
    logic [1:0] m2r, asb, aop;
    {pcw, irw, iord, mrd, mwr, rw, asa, pcs, br, trp} = '0;
    {m2r, asb, aop} = '0;
    case (st)
      S_FETCH:    begin mrd = 1; asb = 2'b01; pcw = rdy; irw = rdy; end
      S_DECODE:   asb = 2'b10;
      S_EXEC_R:   begin asa = 1; aop = 2'b10; end
      S_EXEC_I:   begin asa = 1; asb = 2'b10; aop = 2'b11; end
      S_MEM_ADDR: begin asa = 1; asb = 2'b10; end
      S_MEM_RD:   begin mrd = 1; iord = 1; end
      S_MEM_WR:   begin mwr = 1; iord = 1; end
      S_WB_MEM:   begin rw = 1; m2r = 2'b01; end
      S_WB_ALU:   rw = 1;
      S_BRANCH:   begin asa = 1; aop = 2'b01; br = 1; pcs = 1; end
      S_JAL:      begin rw = 1; m2r = 2'b10; pcw = 1; pcs = 1; end
      S_TRAP:     trp = 1;
      default:    ;
    endcase
    return {pcw, irw, iord, mrd, mwr, m2r, rw, asa, asb, aop, pcs, br, trp};
  endfunction

  // Inputs are stable from #1 after a rising edge until the next one, so compare-then-advance at negedge
  always @(negedge clk) begin
    if (model_valid) begin
      chk("a_state", a_state, m_st[0]);
      chk("a_ctl", ctl_a, exp_ctl(m_st[0], mem_ready));
      chk("a_retired", a_retired, m_ret[0]);
      chk("b_state", b_state, m_st[1]);
      chk("b_ctl", ctl_b, exp_ctl(m_st[1], mem_ready));
      chk("b_retired", b_retired, m_ret[1]);
    end
    model_step(0);
    model_step(1);
    model_valid = 1'b1;
  end

  int exp_add[5]   = '{0, 1, 2, 8, 0};
  int rdy_load[9]  = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
  int exp_load[9]  = '{0, 1, 4, 5, 5, 5, 5, 7, 0};
  int exp_st_b[9]  = '{0, 1, 4, 6, 6, 6, 6, 11, 11};
  int exp_st_a[9]  = '{0, 1, 4, 6, 6, 6, 6, 6, 6};
  int exp_bj[7]    = '{0, 1, 9, 0, 1, 10, 0};
  int exp_wrap[5]  = '{1, 2, 3, 0, 1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic rdy);
    Opcode    = op;
    mem_ready = rdy;
    @(negedge clk);
  endtask

  task automatic rst();
    tick();
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    tick();
    reset_n = 1'b1;
  endtask

  function automatic logic [6:0] pick_op();
    int r;
    r = int'($urandom_range(0, 15));
    if (r < 4)        return OP_R;
    else if (r < 7)   return OP_I;
    else if (r < 9)   return OP_L;
    else if (r < 11)  return OP_S;
    else if (r < 13)  return OP_B;
    else if (r == 13) return OP_J;
    else if (r == 14) return 7'($urandom);
    else              return 7'b1111111;
  endfunction

  initial begin
    int stall;
    reset_n = 1'b0; mem_ready = 1'b0; Opcode = 7'd0;

    // add with zero wait
    rst();
    for (int k = 0; k < 5; k++) begin
      drive(OP_R, 1'b1);
      chk("add_state", a_state, exp_add[k]);
      chk("add_regwrite", a_RegWrite, (k == 3));
      chk("add_retired", a_retired, (k == 4) ? 1 : 0);
      if (k == 0) begin
        chk("rst_memread", a_MemRead, 1);
        chk("rst_alusrcb", a_ALUSrcB, 1);
        chk("rst_trap", a_trap, 0);
      end
      tick();
    end

    // load with three wait cycles in MEM_RD
    rst();
    for (int k = 0; k < 9; k++) begin
      drive(OP_L, rdy_load[k][0]);
      chk("load_state", a_state, exp_load[k]);
      if (k == 7) chk("load_memtoreg", a_MemtoReg, 1);
      if (k == 8) chk("load_retired", a_retired, 1);
      tick();
    end

    // store timeout on the MEM_TIMEOUT=4 instance
    rst();
    for (int k = 0; k < 9; k++) begin
      drive(OP_S, (k < 3) ? 1'b1 : 1'b0);
      chk("store_b_state", b_state, exp_st_b[k]);
      chk("store_a_state", a_state, exp_st_a[k]);
      if (k >= 7) begin
        chk("store_trap", b_trap, 1);
        chk("store_memwrite", b_MemWrite, 0);
      end
      tick();
    end
    rst();
    drive(OP_S, 1'b0);
    chk("trap_clear_state", b_state, 0);
    chk("trap_clear_trap", b_trap, 0);

    // illegal opcode, then jal on the instance without jal support
    rst();
    for (int k = 0; k < 3; k++) begin
      drive(7'b1111111, 1'b1);
      chk("illegal_a_state", a_state, (k == 2) ? 11 : k);
      chk("illegal_b_state", b_state, (k == 2) ? 11 : k);
      tick();
    end
    chk("illegal_retired", a_retired, 0);
    rst();
    for (int k = 0; k < 3; k++) begin
      drive(OP_J, 1'b1);
      chk("jal_b_state", b_state, (k == 2) ? 11 : k);
      chk("jal_a_state", a_state, (k == 2) ? 10 : k);
      tick();
    end
    chk("jal_b_retired", b_retired, 0);

    // branch then jal back to back
    rst();
    for (int k = 0; k < 7; k++) begin
      drive((k < 3) ? OP_B : OP_J, 1'b1);
      chk("bj_state", a_state, exp_bj[k]);
      if (k == 2) begin
        chk("br_branch", a_Branch, 1);
        chk("br_aluop", a_ALUOp, 1);
        chk("br_pcsrc", a_PCSrc, 1);
      end
      if (k == 5) begin
        chk("jal_pcwrite", a_PCWrite, 1);
        chk("jal_memtoreg", a_MemtoReg, 2);
        chk("jal_regwrite", a_RegWrite, 1);
      end
      if (k == 6) chk("bj_retired", a_retired, 2);
      tick();
    end

    // retired wraps on the 2-bit counter
    rst();
    for (int k = 0; k < 21; k++) begin
      drive(OP_R, 1'b1);
      if (k > 0 && k % 4 == 0) begin
        chk("wrap_b_retired", b_retired, exp_wrap[k / 4 - 1]);
        chk("wrap_a_retired", a_retired, k / 4);
      end
      tick();
    end

    // randomized traffic with occasional long stalls and resets
    stall = 0;
    rst();
    repeat (4000) begin
      if ((m_st[0] == S_TRAP || m_st[1] == S_TRAP) && $urandom_range(0, 3) == 0)
        reset_n = 1'b0;
      else
        reset_n = ($urandom_range(0, 199) != 0);
      if (m_st[0] == S_FETCH) Opcode = pick_op();
      if (stall > 0) begin
        mem_ready = 1'b0;
        stall--;
      end else begin
        if ($urandom_range(0, 299) == 0) stall = int'($urandom_range(3, 20));
        mem_ready = ($urandom_range(0, 9) < 7);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
